counter_bank: RTL and testbench
===============================

# counter_bank

Parametrised bank of independent event counters, generalising the single free-running wrap counter to CHANNELS channels. Each channel has a runtime-programmable limit, a wrap or saturate mode, and a sticky overflow flag. Counts are read out over a single valid/ready read port. The bank sits beside the decoder datapath as the shared performance/statistics counter block.

## Interface
- CHANNELS, 4, number of counter channels (≥1)
- WIDTH, 32, counter width in bits
- MAX_DEFAULT, 1000, per-channel limit loaded at reset (must fit WIDTH)
- clk  input  1  clock, all logic on posedge
- rst_n  input  1  reset, asynchronous, active-low
- inc  input  CHANNELS  per-channel increment strobe, one count per high cycle
- clr  input  CHANNELS  per-channel synchronous clear of count and overflow flag
- cfg_we  input  1  config write strobe
- cfg_ch  input  $clog2(CHANNELS) (min 1)  config target channel
- cfg_max  input  WIDTH  new limit
- cfg_sat  input  1  new mode: 0 = wrap, 1 = saturate
- rd_valid  input  1  read request valid
- rd_ch  input  $clog2(CHANNELS) (min 1)  channel to read
- rd_ready  output  1  read request accepted when rd_valid && rd_ready
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response consumed when rsp_valid && rsp_ready
- rsp_count  output  WIDTH  returned count
- rsp_ovf  output  1  returned sticky overflow flag
- wrap  output  CHANNELS  one-cycle pulse per channel on wrap or saturate-hit

## Operation
- Reset: all counts 0, all limits MAX_DEFAULT, all modes wrap, all overflow flags 0, wrap 0, rsp_valid 0, rsp_count 0, rsp_ovf 0.
- Per channel, per cycle, in priority order: clr → count 0, ovf 0; else inc with count ≥ limit → wrap mode: count 0, wrap pulse, ovf 1; saturate mode: count unchanged, wrap pulse, ovf 1; else inc → count + 1; else hold.
- The limit compare is ≥, so a limit lowered below the current count takes effect on the next inc.
- Limit 0: count stays 0 and every inc pulses wrap.
- cfg_we writes limit and mode for cfg_ch; the count is untouched. The new values apply from the next cycle. A same-cycle inc uses the old values.
- Read port is a single-entry buffer: rd_ready = !rsp_valid || rsp_ready.
- On acceptance, rsp_count/rsp_ovf capture the channel's register value at that edge, i.e. pre-update and not including a same-cycle inc.
- Read-to-clear: an accepted read clears that channel's ovf, unless an overflow event or clr occurs the same cycle. Overflow event wins (ovf stays 1); clr clears regardless.
- rsp_valid and rsp_count/rsp_ovf hold stable while rsp_valid && !rsp_ready.
- rd_ch or cfg_ch ≥ CHANNELS: reads return count 0, ovf 0; config writes are ignored.

## Timing
- Count update latency 1 cycle from inc.
- wrap pulse is registered and asserted in the cycle after the qualifying inc edge.
- Read latency 1 cycle. Back-to-back reads sustain 1 per cycle when rsp_ready is held high.
- Mid-operation reset aborts any pending response immediately (asynchronous); no response survives reset.

## Configuration
- COUNTER_BANK_SNAPSHOT_EN defined: adds input snap (1 bit). A snap-high cycle copies all counts and ovf flags into a shadow bank at that edge. Reads return shadow values, and read-to-clear acts on the live flag. The shadow resets to 0.
- Not defined: no snap port, no shadow storage, reads return live values.

## Structure
- Package counter_bank_pkg: mode enum (MODE_WRAP, MODE_SAT) and the channel-index width function.
- One sub-module, counter_channel: holds count, limit, mode and ovf, and implements the priority rules and wrap pulse. counter_bank instantiates CHANNELS of them plus the read mux, response register and optional shadow bank.

## Test plan
- Reset defaults: after reset, read ch0 → rsp_count 0, rsp_ovf 0; 1001 inc on ch0 → one wrap pulse after the 1001st inc, count 0, ovf 1.
- Saturate: cfg ch1 limit 5, sat 1; 8 incs → count holds 5, wrap pulses on incs 6–8, ovf 1. Read → 5/1, second read → 5/0.
- Simultaneous clr+inc on ch2 with count 7 → count 0. Limit lowered to 3 with count 7, then inc → count 0 and wrap pulse.
- Backpressure: rsp_ready low 4 cycles → rsp_count stable, rd_ready low. Release with back-to-back reads ch0..ch3 → 4 responses on consecutive cycles.
- Read ch3 same cycle as its overflow inc → response ovf reflects the pre-edge value, live ovf stays 1.
- Reset asserted with rsp_valid 1 → rsp_valid 0 immediately and all counts 0. With COUNTER_BANK_SNAPSHOT_EN: snap, 3 incs, read → pre-snap value.

Source files
------------

// File: rtl/counter_bank_pkg.sv
// Shared types and helpers for the counter bank: counting mode and channel-index width.
package counter_bank_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    // Width of a channel index; never narrower than one bit so single-channel builds still have a port.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/counter_channel.sv
// One event counter: programmable limit, wrap/saturate mode, sticky overflow and registered wrap pulse.
module counter_channel
    import counter_bank_pkg::*;
#(
    parameter int          WIDTH       = 32,
    parameter int unsigned MAX_DEFAULT = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_max,
    input  logic             cfg_sat,
    input  logic             rd_clr,
    output logic [WIDTH-1:0] count,
    output logic             ovf,
    output logic             wrap
);

    logic [WIDTH-1:0] limit;
    mode_e            mode;
    logic             hit;

    // Compare against the registered limit, so a same-cycle config write only affects later incs.
    assign hit = inc && (count >= limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            limit <= WIDTH'(MAX_DEFAULT);
            mode  <= MODE_WRAP;
            ovf   <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            if (cfg_we) begin
                limit <= cfg_max;
                mode  <= mode_e'(cfg_sat);
            end

            wrap <= hit && !clr;

            if (clr) begin
                count <= '0;
            end else if (hit) begin
                if (mode == MODE_WRAP) begin
                    count <= '0;
                end
            end else if (inc) begin
                count <= count + WIDTH'(1);
            end

            // clr beats everything; an overflow event beats read-to-clear.
            if (clr) begin
                ovf <= 1'b0;
            end else if (hit) begin
                ovf <= 1'b1;
            end else if (rd_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/counter_bank.sv
// Bank of CHANNELS event counters with a single-entry valid/ready read port.
// Optional COUNTER_BANK_SNAPSHOT_EN adds a snap input and a shadow bank that reads are served from.
module counter_bank
    import counter_bank_pkg::*;
#(
    parameter int          CHANNELS    = 4,
    parameter int          WIDTH       = 32,
    parameter int unsigned MAX_DEFAULT = 1000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [CHANNELS-1:0]           inc,
    input  logic [CHANNELS-1:0]           clr,
    input  logic                          cfg_we,
    input  logic [ch_w(CHANNELS)-1:0]     cfg_ch,
    input  logic [WIDTH-1:0]              cfg_max,
    input  logic                          cfg_sat,
`ifdef COUNTER_BANK_SNAPSHOT_EN
    input  logic                          snap,
`endif
    input  logic                          rd_valid,
    input  logic [ch_w(CHANNELS)-1:0]     rd_ch,
    output logic                          rd_ready,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [WIDTH-1:0]              rsp_count,
    output logic                          rsp_ovf,
    output logic [CHANNELS-1:0]           wrap
);

    localparam int CW = ch_w(CHANNELS);

    // Handshake: a request transfers on rd_valid && rd_ready; the response transfers on
    // rsp_valid && rsp_ready. The response register is the only buffer, so a new request
    // is taken only when it is empty or being drained in the same cycle.

    logic [WIDTH-1:0]    live_count [CHANNELS];
    logic [CHANNELS-1:0] live_ovf;
    logic [CHANNELS-1:0] cfg_sel;
    logic [CHANNELS-1:0] rd_clr;
    logic                rd_fire;
    logic [WIDTH-1:0]    sel_count;
    logic                sel_ovf;

    assign rd_ready = !rsp_valid || rsp_ready;
    assign rd_fire  = rd_valid && rd_ready;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        // Out-of-range indices match no channel, so such writes and reads fall through harmlessly.
        assign cfg_sel[g] = cfg_we && (cfg_ch == CW'(g));
        assign rd_clr[g]  = rd_fire && (rd_ch == CW'(g));

        counter_channel #(
            .WIDTH       (WIDTH),
            .MAX_DEFAULT (MAX_DEFAULT)
        ) u_channel (
            .clk     (clk),
            .rst_n   (rst_n),
            .inc     (inc[g]),
            .clr     (clr[g]),
            .cfg_we  (cfg_sel[g]),
            .cfg_max (cfg_max),
            .cfg_sat (cfg_sat),
            .rd_clr  (rd_clr[g]),
            .count   (live_count[g]),
            .ovf     (live_ovf[g]),
            .wrap    (wrap[g])
        );
    end

`ifdef COUNTER_BANK_SNAPSHOT_EN
    logic [WIDTH-1:0]    shadow_count [CHANNELS];
    logic [CHANNELS-1:0] shadow_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_count[i] <= '0;
            end
            shadow_ovf <= '0;
        end else if (snap) begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_count[i] <= live_count[i];
            end
            shadow_ovf <= live_ovf;
        end
    end

    always_comb begin
        sel_count = '0;
        sel_ovf   = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (rd_ch == CW'(i)) begin
                sel_count = shadow_count[i];
                sel_ovf   = shadow_ovf[i];
            end
        end
    end
`else
    always_comb begin
        sel_count = '0;
        sel_ovf   = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (rd_ch == CW'(i)) begin
                sel_count = live_count[i];
                sel_ovf   = live_ovf[i];
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_count <= '0;
            rsp_ovf   <= 1'b0;
        end else if (rd_fire) begin
            rsp_valid <= 1'b1;
            rsp_count <= sel_count;
            rsp_ovf   <= sel_ovf;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_counter_bank.sv
// Directed scoreboard bench for counter_bank: expected responses are queued at issue and checked by a monitor.
module tb_counter_bank;

    localparam int CHANNELS = 4;
    localparam int WIDTH    = 32;
    localparam int CW       = 2;

    logic                clk;
    logic                rst_n;
    logic [CHANNELS-1:0] inc;
    logic [CHANNELS-1:0] clr;
    logic                cfg_we;
    logic [CW-1:0]       cfg_ch;
    logic [WIDTH-1:0]    cfg_max;
    logic                cfg_sat;
    logic                snap;
    logic                rd_valid;
    logic [CW-1:0]       rd_ch;
    logic                rd_ready;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [WIDTH-1:0]    rsp_count;
    logic                rsp_ovf;
    logic [CHANNELS-1:0] wrap;

    int tests = 0;
    int fails = 0;
    int rsp_seen = 0;
    int wrap_cnt [CHANNELS];

    logic [WIDTH:0] exp_q[$];

    counter_bank #(
        .CHANNELS    (CHANNELS),
        .WIDTH       (WIDTH),
        .MAX_DEFAULT (1000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (inc),
        .clr       (clr),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_max   (cfg_max),
        .cfg_sat   (cfg_sat),
`ifdef COUNTER_BANK_SNAPSHOT_EN
        .snap      (snap),
`endif
        .rd_valid  (rd_valid),
        .rd_ch     (rd_ch),
        .rd_ready  (rd_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_count (rsp_count),
        .rsp_ovf   (rsp_ovf),
        .wrap      (wrap)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Checker
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: responses transfer at the next posedge when valid && ready at the negedge.
    always @(negedge clk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (wrap[i]) wrap_cnt[i]++;
        end
        if (rst_n && rsp_valid && rsp_ready) begin
            rsp_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 64'(rsp_valid), 64'd0);
            end else begin
                logic [WIDTH:0] e;
                e = exp_q.pop_front();
                check("rsp", 64'({rsp_ovf, rsp_count}), 64'(e));
            end
        end
    end

    // Drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_inc(input int ch, input int n);
        inc = '0;
        inc[ch] = 1'b1;
        repeat (n) tick();
        inc = '0;
    endtask

    task automatic do_cfg(input int ch, input logic [WIDTH-1:0] mx, input logic sat);
        cfg_we  = 1'b1;
        cfg_ch  = CW'(ch);
        cfg_max = mx;
        cfg_sat = sat;
        tick();
        cfg_we  = 1'b0;
    endtask

    // Issue one read and let the response drain (rsp_ready assumed high).
    task automatic do_read(input int ch, input logic [WIDTH-1:0] ec, input logic eo);
        exp_q.push_back({eo, ec});
        rd_valid = 1'b1;
        rd_ch    = CW'(ch);
        tick();
        rd_valid = 1'b0;
        tick();
    endtask

    int w0;

    initial begin
        for (int i = 0; i < CHANNELS; i++) wrap_cnt[i] = 0;
        rst_n = 1'b0; inc = '0; clr = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_max = '0;
        cfg_sat = 1'b0; snap = 1'b0; rd_valid = 1'b0; rd_ch = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset defaults
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_count", 64'(rsp_count), 64'd0);
        check("reset_rsp_ovf",   64'(rsp_ovf),   64'd0);
        check("reset_wrap",      64'(wrap),      64'd0);
        check("reset_rd_ready",  64'(rd_ready),  64'd1);
        do_read(0, 0, 1'b0);

        // Default limit 1000: the 1001st inc wraps
        w0 = wrap_cnt[0];
        do_inc(0, 1000);
        tick();
        check("ch0_no_wrap_1000", 64'(wrap_cnt[0] - w0), 64'd0);
        do_read(0, 1000, 1'b0);
        do_inc(0, 1);
        tick();
        check("ch0_wrap_1001", 64'(wrap_cnt[0] - w0), 64'd1);
        do_read(0, 0, 1'b1);
        do_read(0, 0, 1'b0);

        // Saturate on ch1 with limit 5
        do_cfg(1, 5, 1'b1);
        w0 = wrap_cnt[1];
        do_inc(1, 5);
        tick();
        check("ch1_sat_no_wrap", 64'(wrap_cnt[1] - w0), 64'd0);
        do_inc(1, 3);
        tick();
        check("ch1_sat_wraps", 64'(wrap_cnt[1] - w0), 64'd3);
        do_read(1, 5, 1'b1);
        do_read(1, 5, 1'b0);

        // clr beats inc; lowered limit takes effect on next inc
        do_inc(2, 7);
        clr[2] = 1'b1; inc[2] = 1'b1;
        tick();
        clr = '0; inc = '0;
        do_read(2, 0, 1'b0);
        do_inc(2, 7);
        do_cfg(2, 3, 1'b0);
        w0 = wrap_cnt[2];
        do_inc(2, 1);
        tick();
        check("ch2_lowered_wrap", 64'(wrap_cnt[2] - w0), 64'd1);
        do_read(2, 0, 1'b1);

        // Same-cycle cfg uses old limit; then limit 0 wraps on every inc
        cfg_we = 1'b1; cfg_ch = 2'd2; cfg_max = 0; cfg_sat = 1'b0; inc[2] = 1'b1;
        tick();
        cfg_we = 1'b0; inc = '0;
        tick();
        check("ch2_cfg_same_cycle", 64'(wrap_cnt[2] - w0), 64'd1);
        do_read(2, 1, 1'b0);
        do_inc(2, 2);
        tick();
        check("ch2_limit0_wraps", 64'(wrap_cnt[2] - w0), 64'd3);
        do_read(2, 0, 1'b1);

        // Backpressure then back-to-back reads
        do_inc(0, 3);
        do_inc(3, 2);
        rsp_ready = 1'b0;
        exp_q.push_back({1'b0, 32'd5});
        rd_valid = 1'b1; rd_ch = 2'd1;
        tick();
        rd_ch = 2'd0;
        for (int i = 0; i < 4; i++) begin
            check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            check("bp_rd_ready",  64'(rd_ready),  64'd0);
            check("bp_rsp_count", 64'(rsp_count), 64'd5);
            tick();
        end
        w0 = rsp_seen;
        rsp_ready = 1'b1;
        exp_q.push_back({1'b0, 32'd3});
        exp_q.push_back({1'b0, 32'd5});
        exp_q.push_back({1'b0, 32'd0});
        exp_q.push_back({1'b0, 32'd2});
        for (int i = 0; i < 4; i++) begin
            rd_ch = CW'(i);
            tick();
            check("b2b_rsp_valid", 64'(rsp_valid), 64'd1);
        end
        rd_valid = 1'b0;
        tick();
        check("b2b_rsp_total", 64'(rsp_seen - w0), 64'd5);

        // Read ch3 in the same cycle as its overflow inc
        do_cfg(3, 2, 1'b0);
        w0 = wrap_cnt[3];
        exp_q.push_back({1'b0, 32'd2});
        rd_valid = 1'b1; rd_ch = 2'd3; inc[3] = 1'b1;
        tick();
        rd_valid = 1'b0; inc = '0;
        tick();
        check("ch3_ovf_wrap", 64'(wrap_cnt[3] - w0), 64'd1);
        do_read(3, 0, 1'b1);

        // Reset with a pending response
        do_inc(1, 0);
        rsp_ready = 1'b0;
        exp_q.push_back({1'b0, 32'd3});
        rd_valid = 1'b1; rd_ch = 2'd0;
        tick();
        rd_valid = 1'b0;
        check("pre_reset_rsp_valid", 64'(rsp_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_rsp_valid", 64'(rsp_valid), 64'd0);
        void'(exp_q.pop_back());
        tick();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        do_read(0, 0, 1'b0);
        do_read(1, 0, 1'b0);
        w0 = wrap_cnt[0];
        do_inc(0, 1000);
        tick();
        check("post_reset_limit", 64'(wrap_cnt[0] - w0), 64'd0);
        do_read(0, 1000, 1'b0);

`ifdef COUNTER_BANK_SNAPSHOT_EN
        // Snapshot: reads return the shadow copy
        do_inc(2, 2);
        snap = 1'b1;
        tick();
        snap = 1'b0;
        do_inc(2, 3);
        do_read(2, 2, 1'b0);
`endif

        repeat (3) tick();
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
